// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
//   Shared types and defaults for the MIPS Avalon-style bus arbiter slice.
//   arb_state_t        : arbiter FSM encoding (IDLE, GRANT0, GRANT1)
//   DEFAULT_ADDR_W     : default address width
//   DEFAULT_DATA_W     : default data width
//   DEFAULT_ABORT_DATA : readdata returned to a master on a watchdog abort
package mips_bus_pkg;

   localparam int unsigned DEFAULT_ADDR_W = 32;
   localparam int unsigned DEFAULT_DATA_W = 32;
   localparam logic [31:0] DEFAULT_ABORT_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mips_bus_watchdog.sv
// mips_bus_watchdog
//   Counts granted cycles in which the slave holds waitrequest and flags
//   expiry once TIMEOUT_CYCLES such cycles have elapsed. TIMEOUT_CYCLES = 0
//   disables expiry entirely.
//   clk      in  : clock (posedge)
//   rst_n    in  : asynchronous active-low reset
//   clear    in  : synchronous clear (held while the arbiter is idle)
//   count_en in  : increment this cycle (granted and slave stalling)
//   expired  out : count has reached TIMEOUT_CYCLES
module mips_bus_watchdog
   import mips_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count_q;

   // Counter freezes at the limit so expiry stays asserted until cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (count_en && !expired) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expired = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Two-master, one-slave arbiter for the MIPS Avalon-style memory bus.
//   Master 0 is the CPU bus port, master 1 the loader/DMA port. One master
//   is granted per transaction; its request is forwarded to the slave and
//   readdata/waitrequest are routed back. A watchdog aborts transactions the
//   slave never completes.
//   Build option: MIPS_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking;
//   undefined gives fixed priority to master 0.
//   Ports:
//     clk, rst_n                      : clock, async active-low reset
//     mN_address/read/write/
//       byteenable/writedata    (in)  : master N request
//     mN_readdata/waitrequest   (out) : master N response
//     s_address/read/write/
//       byteenable/writedata    (out) : slave request
//     s_readdata/waitrequest    (in)  : slave response
//     grant                     (out) : registered one-hot grant, 00 idle
//     timeout_err               (out) : sticky watchdog abort flag
module mips_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int unsigned ADDR_W          = DEFAULT_ADDR_W,
   parameter int unsigned DATA_W          = DEFAULT_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES  = 255,
   parameter logic [DATA_W-1:0] ABORT_DATA = DATA_W'(DEFAULT_ABORT_DATA)
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_waitrequest,

   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_waitrequest,

   output logic [ADDR_W-1:0]     s_address,
   output logic                  s_read,
   output logic                  s_write,
   output logic [DATA_W/8-1:0]   s_byteenable,
   output logic [DATA_W-1:0]     s_writedata,
   input  logic [DATA_W-1:0]     s_readdata,
   input  logic                  s_waitrequest,

   output logic [1:0]            grant,
   output logic                  timeout_err
);

   arb_state_t state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       timeout_err_q, set_err;
   logic       req0, req1;
   logic       wd_expired;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
   // 1 means master 1 was granted most recently.
   logic last_grant_q, last_grant_d;
`endif

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   mips_bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (state_q == IDLE),
      .count_en ((state_q != IDLE) && s_waitrequest),
      .expired  (wd_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         timeout_err_q <= 1'b0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
         last_grant_q  <= 1'b1;
`endif
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         if (set_err) begin
            timeout_err_q <= 1'b1;
         end
`ifdef MIPS_ARB_ROUND_ROBIN_EN
         last_grant_q  <= last_grant_d;
`endif
      end
   end

   // Next state. Every transaction passes back through IDLE so a master
   // still holding its request at the completion edge is not re-granted.
   always_comb begin
      state_d = state_q;
      set_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 && req1) begin
`ifdef MIPS_ARB_ROUND_ROBIN_EN
               state_d = last_grant_q ? GRANT0 : GRANT1;
`else
               state_d = GRANT0;
`endif
            end else if (req0) begin
               state_d = GRANT0;
            end else if (req1) begin
               state_d = GRANT1;
            end
         end
         GRANT0: begin
            if (wd_expired) begin
               state_d = IDLE;
               set_err = 1'b1;
            end else if (!req0 || !s_waitrequest) begin
               state_d = IDLE;
            end
         end
         GRANT1: begin
            if (wd_expired) begin
               state_d = IDLE;
               set_err = 1'b1;
            end else if (!req1 || !s_waitrequest) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      grant_d = {state_d == GRANT1, state_d == GRANT0};

`ifdef MIPS_ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
      if (state_d == GRANT0) begin
         last_grant_d = 1'b0;
      end else if (state_d == GRANT1) begin
         last_grant_d = 1'b1;
      end
`endif
   end

   // Request/response muxing. An abort kills the slave strobes and releases
   // the master in the same cycle with ABORT_DATA.
   always_comb begin
      s_address      = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_byteenable   = '0;
      s_writedata    = '0;
      m0_readdata    = '0;
      m0_waitrequest = 1'b1;
      m1_readdata    = '0;
      m1_waitrequest = 1'b1;
      case (state_q)
         GRANT0: begin
            s_address      = m0_address;
            s_byteenable   = m0_byteenable;
            s_writedata    = m0_writedata;
            s_write        = m0_write & ~wd_expired;
            s_read         = m0_read & ~m0_write & ~wd_expired;
            m0_waitrequest = s_waitrequest & ~wd_expired;
            m0_readdata    = wd_expired ? ABORT_DATA : s_readdata;
         end
         GRANT1: begin
            s_address      = m1_address;
            s_byteenable   = m1_byteenable;
            s_writedata    = m1_writedata;
            s_write        = m1_write & ~wd_expired;
            s_read         = m1_read & ~m1_write & ~wd_expired;
            m1_waitrequest = s_waitrequest & ~wd_expired;
            m1_readdata    = wd_expired ? ABORT_DATA : s_readdata;
         end
         default: ;
      endcase
   end

   assign grant       = grant_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter
//   Directed self-checking bench for mips_bus_arbiter (TIMEOUT_CYCLES = 4).
//   Expectations follow MIPS_ARB_ROUND_ROBIN_EN when the macro is defined.
module tb_mips_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [31:0] m0_address, m1_address, s_address;
   logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
   logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
   logic [31:0] m0_writedata, m1_writedata, s_writedata;
   logic [31:0] m0_readdata, m1_readdata, s_readdata;
   logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
   logic [1:0]  grant;
   logic        timeout_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_bus_arbiter #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (4),
      .ABORT_DATA     (32'hDEADBEEF)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .m0_address     (m0_address),
      .m0_read        (m0_read),
      .m0_write       (m0_write),
      .m0_byteenable  (m0_byteenable),
      .m0_writedata   (m0_writedata),
      .m0_readdata    (m0_readdata),
      .m0_waitrequest (m0_waitrequest),
      .m1_address     (m1_address),
      .m1_read        (m1_read),
      .m1_write       (m1_write),
      .m1_byteenable  (m1_byteenable),
      .m1_writedata   (m1_writedata),
      .m1_readdata    (m1_readdata),
      .m1_waitrequest (m1_waitrequest),
      .s_address      (s_address),
      .s_read         (s_read),
      .s_write        (s_write),
      .s_byteenable   (s_byteenable),
      .s_writedata    (s_writedata),
      .s_readdata     (s_readdata),
      .s_waitrequest  (s_waitrequest),
      .grant          (grant),
      .timeout_err    (timeout_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_masters;
      m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = '0; m0_writedata = '0;
      m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = '0; m1_writedata = '0;
   endtask

   task automatic reset_dut;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      idle_masters();
      s_waitrequest = 1'b1;
      s_readdata = '0;
      rst_n = 1'b0;
      #2;
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b want 00", grant); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
      checks++; if (s_read !== 1'b0 || s_write !== 1'b0) begin failures++; $display("FAIL reset_s_rw: got %b%b want 00", s_read, s_write); end
      checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin failures++; $display("FAIL reset_waitreq: got %b%b want 11", m0_waitrequest, m1_waitrequest); end
      checks++; if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata: got %h %h want 0 0", m0_readdata, m1_readdata); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read;
      m0_address = 32'h0000_0010; m0_read = 1'b1; m0_byteenable = 4'hF;
      s_waitrequest = 1'b0; s_readdata = 32'h1234_5678;
      #1;
      checks++; if (grant !== 2'b00 || m0_waitrequest !== 1'b1) begin failures++; $display("FAIL single_pre: got grant=%b wr=%b want 00 1", grant, m0_waitrequest); end
      tick();
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_grant: got %b want 01", grant); end
      checks++; if (s_read !== 1'b1 || s_address !== 32'h10) begin failures++; $display("FAIL single_s_req: got rd=%b addr=%h want 1 00000010", s_read, s_address); end
      checks++; if (m0_readdata !== 32'h1234_5678 || m0_waitrequest !== 1'b0) begin failures++; $display("FAIL single_resp: got %h wr=%b want 12345678 0", m0_readdata, m0_waitrequest); end
      checks++; if (m1_waitrequest !== 1'b1 || m1_readdata !== 32'h0) begin failures++; $display("FAIL single_m1_blocked: got wr=%b rd=%h want 1 0", m1_waitrequest, m1_readdata); end
      tick();
      m0_read = 1'b0;
      #1;
      checks++; if (grant !== 2'b00 || m0_waitrequest !== 1'b1 || s_read !== 1'b0) begin failures++; $display("FAIL single_idle: got grant=%b wr=%b rd=%b want 00 1 0", grant, m0_waitrequest, s_read); end
   endtask

   task automatic test_simultaneous;
      logic [1:0] exp_g [6];
      logic       w0, w1;
      int         m0_done;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
`else
      exp_g = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
`endif
      reset_dut();
      m0_done = 0;
      m0_write = 1'b1; m0_address = 32'h20; m0_writedata = 32'hCAFE_0001; m0_byteenable = 4'hF;
      m1_read = 1'b1;  m1_address = 32'h30; m1_byteenable = 4'hF;
      s_waitrequest = 1'b0; s_readdata = 32'h0000_3030;
      for (int i = 0; i < 6; i++) begin
         #1;
         w0 = m0_waitrequest;
         w1 = m1_waitrequest;
         tick();
         checks++; if (grant !== exp_g[i]) begin failures++; $display("FAIL simul_grant[%0d]: got %b want %b", i, grant, exp_g[i]); end
         if (exp_g[i] == 2'b01) begin
            checks++; if (m1_waitrequest !== 1'b1 || s_write !== 1'b1 || s_writedata !== 32'hCAFE_0001) begin failures++; $display("FAIL simul_m0_phase[%0d]: got m1wr=%b sw=%b wd=%h want 1 1 cafe0001", i, m1_waitrequest, s_write, s_writedata); end
         end else if (exp_g[i] == 2'b10) begin
            checks++; if (m0_waitrequest !== 1'b1 || s_read !== 1'b1 || s_address !== 32'h30 || m1_readdata !== 32'h0000_3030) begin failures++; $display("FAIL simul_m1_phase[%0d]: got m0wr=%b sr=%b addr=%h rd=%h want 1 1 00000030 00003030", i, m0_waitrequest, s_read, s_address, m1_readdata); end
         end
         if (!w0 && m0_write) begin
            m0_done++;
            if (m0_done >= 2) m0_write = 1'b0;
         end
         if (!w1 && m1_read) m1_read = 1'b0;
      end
      idle_masters();
   endtask

   task automatic test_wait_states;
      logic [1:0] exp_g;
      logic       exp_w;
      s_waitrequest = 1'b1; s_readdata = 32'h55AA_55AA;
      m1_read = 1'b1; m1_address = 32'h40; m1_byteenable = 4'hF;
      for (int e = 1; e <= 5; e++) begin
         tick();
         if (e == 4) begin
            s_waitrequest = 1'b0;
            #1;
         end
         exp_g = (e < 5) ? 2'b10 : 2'b00;
         exp_w = (e < 4) ? 1'b1 : 1'b0;
         checks++; if (grant !== exp_g) begin failures++; $display("FAIL wait_grant[e%0d]: got %b want %b", e, grant, exp_g); end
         if (e < 5) begin
            checks++; if (s_read !== 1'b1 || s_address !== 32'h40 || s_byteenable !== 4'hF) begin failures++; $display("FAIL wait_stable[e%0d]: got rd=%b addr=%h be=%h want 1 00000040 f", e, s_read, s_address, s_byteenable); end
            checks++; if (m1_waitrequest !== exp_w || m0_waitrequest !== 1'b1) begin failures++; $display("FAIL wait_waitreq[e%0d]: got m1=%b m0=%b want %b 1", e, m1_waitrequest, m0_waitrequest, exp_w); end
         end
         if (e == 4) begin
            checks++; if (m1_readdata !== 32'h55AA_55AA) begin failures++; $display("FAIL wait_readdata: got %h want 55aa55aa", m1_readdata); end
         end
      end
      idle_masters();
   endtask

   task automatic test_timeout;
      s_waitrequest = 1'b1; s_readdata = 32'h1111_1111;
      m0_read = 1'b1; m0_address = 32'h50; m0_byteenable = 4'hF;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e <= 4) begin
            checks++; if (grant !== 2'b01 || m0_waitrequest !== 1'b1 || s_read !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_stall[e%0d]: got g=%b wr=%b rd=%b err=%b want 01 1 1 0", e, grant, m0_waitrequest, s_read, timeout_err); end
         end else if (e == 5) begin
            checks++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL to_abort_resp: got wr=%b rd=%h want 0 deadbeef", m0_waitrequest, m0_readdata); end
            checks++; if (s_read !== 1'b0 || s_write !== 1'b0 || grant !== 2'b01 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_abort_bus: got sr=%b sw=%b g=%b err=%b want 0 0 01 0", s_read, s_write, grant, timeout_err); end
         end else begin
            checks++; if (timeout_err !== 1'b1 || grant !== 2'b00) begin failures++; $display("FAIL to_after: got err=%b g=%b want 1 00", timeout_err, grant); end
         end
      end
      m0_read = 1'b0;
      tick();
      s_waitrequest = 1'b0; s_readdata = 32'h0BAD_F00D;
      m0_read = 1'b1; m0_address = 32'h60;
      tick();
      checks++; if (grant !== 2'b01 || m0_readdata !== 32'h0BAD_F00D || m0_waitrequest !== 1'b0) begin failures++; $display("FAIL to_next_txn: got g=%b rd=%h wr=%b want 01 0badf00d 0", grant, m0_readdata, m0_waitrequest); end
      tick();
      m0_read = 1'b0;
      #1;
      checks++; if (grant !== 2'b00 || timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky: got g=%b err=%b want 00 1", grant, timeout_err); end
      idle_masters();
   endtask

   task automatic test_reset_mid;
      s_waitrequest = 1'b1;
      m1_write = 1'b1; m1_address = 32'h70; m1_writedata = 32'h1; m1_byteenable = 4'hF;
      tick();
      checks++; if (grant !== 2'b10 || s_write !== 1'b1) begin failures++; $display("FAIL rstmid_pre: got g=%b sw=%b want 10 1", grant, s_write); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (s_read !== 1'b0 || s_write !== 1'b0 || grant !== 2'b00) begin failures++; $display("FAIL rstmid_bus: got sr=%b sw=%b g=%b want 0 0 00", s_read, s_write, grant); end
      checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL rstmid_resp: got wr0=%b wr1=%b err=%b want 1 1 0", m0_waitrequest, m1_waitrequest, timeout_err); end
      idle_masters();
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_byte_write;
      s_waitrequest = 1'b0; s_readdata = '0;
      m1_write = 1'b1; m1_address = 32'h100; m1_writedata = 32'h00AB_0000; m1_byteenable = 4'b0100;
      #1;
      checks++; if (s_byteenable !== 4'h0 || s_writedata !== 32'h0 || s_address !== 32'h0 || s_write !== 1'b0) begin failures++; $display("FAIL bw_idle_pre: got be=%b wd=%h addr=%h sw=%b want 0000 0 0 0", s_byteenable, s_writedata, s_address, s_write); end
      tick();
      checks++; if (s_byteenable !== 4'b0100 || s_writedata !== 32'h00AB_0000 || s_address !== 32'h100 || s_write !== 1'b1 || s_read !== 1'b0) begin failures++; $display("FAIL bw_grant: got be=%b wd=%h addr=%h sw=%b sr=%b want 0100 00ab0000 00000100 1 0", s_byteenable, s_writedata, s_address, s_write, s_read); end
      tick();
      m1_write = 1'b0;
      #1;
      checks++; if (s_byteenable !== 4'h0 || s_writedata !== 32'h0 || s_address !== 32'h0 || grant !== 2'b00) begin failures++; $display("FAIL bw_idle_post: got be=%b wd=%h addr=%h g=%b want 0000 0 0 00", s_byteenable, s_writedata, s_address, grant); end
      idle_masters();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_wait_states();
      test_timeout();
      test_reset_mid();
      test_byte_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_time_limit: got still running want finished");
      $fatal(1, "time limit");
   end

endmodule
